// File: rtl/bcd_sseg_scan.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Captures packed BCD on a strobe, scans digits with a dark guard interval between them.
module bcd_sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_vld,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       idx_r, idx_s;
  logic             first_r, first_s;
  logic [15:0]      latch_r, latch_s;
  logic [3:0]       an_r, an_s;
  logic [6:0]       seg_r, seg_s;
  logic [3:0]       nib_s;
  logic [3:0]       blank_s;

  // Next-state, capture and output computation; outputs use next-state values.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    first_s = first_r;
    latch_s = latch_r;
    an_s    = 4'b1111;
    seg_s   = 7'b1111111;
    nib_s   = 4'd0;
    blank_s = 4'b0000;

    if (bcd_vld) begin
      latch_s = bcd_in;
    end else begin
      latch_s = latch_r;
    end

    case (state_r)
      ST_GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_DRIVE;
          first_s = 1'b0;
          // The first exit from reset starts on digit 0 rather than advancing.
          if (first_r) begin
            idx_s = idx_r;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == DRIVE_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_GUARD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_GUARD;
      end
    endcase

    // A digit is a leading zero only if it and every higher digit are zero.
    blank_s[3] = blank_en && (latch_s[15:12] == 4'd0);
    blank_s[2] = blank_s[3] && (latch_s[11:8] == 4'd0);
    blank_s[1] = blank_s[2] && (latch_s[7:4] == 4'd0);
    blank_s[0] = 1'b0;

    case (idx_s)
      2'd0:    nib_s = latch_s[3:0];
      2'd1:    nib_s = latch_s[7:4];
      2'd2:    nib_s = latch_s[11:8];
      2'd3:    nib_s = latch_s[15:12];
      default: nib_s = 4'd0;
    endcase

    if (state_s == ST_DRIVE) begin
      an_s = ~(4'b0001 << idx_s);
      if (blank_s[idx_s]) begin
        seg_s = 7'b1111111;
      end else begin
        seg_s = seg_decode(nib_s);
      end
    end else begin
      an_s  = 4'b1111;
      seg_s = 7'b1111111;
    end
  end

  // State, latch and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_GUARD;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 2'd0;
      first_r <= 1'b1;
      latch_r <= 16'h0000;
      an_r    <= 4'b1111;
      seg_r   <= 7'b1111111;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      first_r <= first_s;
      latch_r <= latch_s;
      an_r    <= an_s;
      seg_r   <= seg_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = 1'b1;

endmodule
